// File: rtl/alu_seq.sv
// Multi-cycle ALU: single-cycle logic/arith ops, iterative shift-add MUL and restoring DIV.
// Result and flags are registered and announced by a one-cycle done pulse.
module alu_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] data_a,
  input  logic [WIDTH-1:0] data_b,
  output logic [WIDTH-1:0] result,
  output logic             done,
  output logic             busy,
  output logic             zflag,
  output logic             cflag,
  output logic             dzflag
);

  localparam logic [2:0] OP_ADD = 3'b000, OP_SUB = 3'b001, OP_AND = 3'b010, OP_OR = 3'b011,
                         OP_XOR = 3'b100, OP_PASSB = 3'b101, OP_MUL = 3'b110, OP_DIV = 3'b111;
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             is_div_q, is_div_d;
  logic [WIDTH-1:0] acc_q, acc_d;    // MUL partial product
  logic [WIDTH-1:0] opb_q, opb_d;    // MUL multiplicand (shifts left) / DIV divisor
  logic [WIDTH-1:0] shf_q, shf_d;    // MUL multiplier (shifts right) / DIV dividend -> quotient
  logic [WIDTH:0]   rem_q, rem_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zf_q, zf_d, cf_q, cf_d, dzf_q, dzf_d, done_q, done_d;

  logic [WIDTH:0]   add_w, sub_w, rem_sh;
  logic [WIDTH-1:0] alu_res, fin_res;
  logic             alu_c, iter_op;

  assign add_w   = {1'b0, data_a} + {1'b0, data_b};
  assign sub_w   = {1'b0, data_a} - {1'b0, data_b};
  assign rem_sh  = {rem_q[WIDTH-1:0], shf_q[WIDTH-1]};
  assign fin_res = is_div_q ? shf_q : acc_q;
  assign iter_op = (op == OP_MUL) || ((op == OP_DIV) && (data_b != '0));

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    case (op)
      OP_ADD:   begin alu_res = add_w[WIDTH-1:0]; alu_c = add_w[WIDTH]; end
      OP_SUB:   begin alu_res = sub_w[WIDTH-1:0]; alu_c = sub_w[WIDTH]; end
      OP_AND:   alu_res = data_a & data_b;
      OP_OR:    alu_res = data_a | data_b;
      OP_XOR:   alu_res = data_a ^ data_b;
      OP_PASSB: alu_res = data_b;
      default:  alu_res = '0;
    endcase
  end

  // State register plus datapath flops
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      acc_q    <= '0;
      opb_q    <= '0;
      shf_q    <= '0;
      rem_q    <= '0;
      result_q <= '0;
      zf_q     <= 1'b1;
      cf_q     <= 1'b0;
      dzf_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      acc_q    <= acc_d;
      opb_q    <= opb_d;
      shf_q    <= shf_d;
      rem_q    <= rem_d;
      result_q <= result_d;
      zf_q     <= zf_d;
      cf_q     <= cf_d;
      dzf_q    <= dzf_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start && iter_op) state_d = CALC;
      CALC:    if (cnt_q == LAST) state_d = FIN;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    acc_d    = acc_q;
    opb_d    = opb_q;
    shf_d    = shf_q;
    rem_d    = rem_q;
    result_d = result_q;
    zf_d     = zf_q;
    cf_d     = cf_q;
    dzf_d    = dzf_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        if (iter_op) begin
          cnt_d    = '0;
          is_div_d = (op == OP_DIV);
          acc_d    = '0;
          rem_d    = '0;
          opb_d    = data_b;
          shf_d    = data_a;
        end else if (op == OP_DIV) begin
          result_d = '1;
          zf_d     = 1'b0;
          cf_d     = 1'b0;
          dzf_d    = 1'b1;
          done_d   = 1'b1;
        end else begin
          result_d = alu_res;
          zf_d     = (alu_res == '0);
          cf_d     = alu_c;
          dzf_d    = 1'b0;
          done_d   = 1'b1;
        end
      end
      CALC: begin
        cnt_d = cnt_q + CW'(1);
        if (is_div_q) begin
          // Restoring step: shift next dividend bit into remainder, subtract if it fits
          if (rem_sh >= {1'b0, opb_q}) begin
            rem_d = rem_sh - {1'b0, opb_q};
            shf_d = {shf_q[WIDTH-2:0], 1'b1};
          end else begin
            rem_d = rem_sh;
            shf_d = {shf_q[WIDTH-2:0], 1'b0};
          end
        end else begin
          acc_d = acc_q + (shf_q[0] ? opb_q : '0);
          opb_d = opb_q << 1;
          shf_d = shf_q >> 1;
        end
      end
      FIN: begin
        result_d = fin_res;
        zf_d     = (fin_res == '0);
        cf_d     = 1'b0;
        dzf_d    = 1'b0;
        done_d   = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    busy   = (state_q != IDLE);
    done   = done_q;
    result = result_q;
    zflag  = zf_q;
    cflag  = cf_q;
    dzflag = dzf_q;
  end

endmodule
